// File: rtl/corner_lock_scheduler_if.sv
// Signal bundle between the overlay sequencer and its environment.
// Every strobe is a one-cycle pulse. None of them uses back-pressure:
// a pulse is consumed in the cycle it is seen, and o_addr_valid qualifies
// o_enable together with the four corner addresses.
interface corner_lock_scheduler_if;
    logic        i_frame_start;
    logic        i_user_enable;
    logic        i_det_valid;
    logic [19:0] i_det_ul;
    logic [19:0] i_det_ur;
    logic [19:0] i_det_dl;
    logic [19:0] i_det_dr;
    logic        i_xform_done;
    logic        o_addr_valid;
    logic        o_enable;
    logic [19:0] o_ul_addr;
    logic [19:0] o_ur_addr;
    logic [19:0] o_dl_addr;
    logic [19:0] o_dr_addr;
    logic        o_locked;
    logic [1:0]  o_state;

    modport master (
        output i_frame_start, i_user_enable, i_det_valid,
        output i_det_ul, i_det_ur, i_det_dl, i_det_dr, i_xform_done,
        input  o_addr_valid, o_enable, o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr,
        input  o_locked, o_state
    );

    modport slave (
        input  i_frame_start, i_user_enable, i_det_valid,
        input  i_det_ul, i_det_ur, i_det_dl, i_det_dr, i_xform_done,
        output o_addr_valid, o_enable, o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr,
        output o_locked, o_state
    );
endinterface

// File: rtl/corner_lock_scheduler.sv
// Filters per-frame corner detections and issues overlay commit strobes only
// at frame boundaries, once the downstream perspective solve has finished.
module corner_lock_scheduler #(
    parameter int STABLE_FRAMES = 4,
    parameter int LOST_FRAMES   = 8,
    parameter int TOL           = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    corner_lock_scheduler_if.slave  bus
);
    localparam int MAX_FRAMES = (STABLE_FRAMES > LOST_FRAMES) ? STABLE_FRAMES : LOST_FRAMES;
    localparam int CW = $clog2(MAX_FRAMES + 1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_FRAMES);
    localparam logic [CW-1:0] LOST_MAX   = CW'(LOST_FRAMES);

    typedef enum logic [1:0] {
        S_DISABLED   = 2'd0,
        S_ACQUIRE    = 2'd1,
        S_WAIT_XFORM = 2'd2,
        S_LOCKED     = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_det_valid;
    logic [79:0]   r_det;
    logic [79:0]   r_cand, w_cand_nxt, w_acq_cand;
    logic [CW-1:0] r_stable, w_stable_nxt, w_acq_stable;
    logic [CW-1:0] r_lost, w_lost_nxt;
    logic [79:0]   r_out;
    logic          r_addr_valid, r_enable;
    logic          w_commit, w_commit_en;
    logic          w_geom_ok, w_capture, w_match_cand, w_match_out;
    logic [79:0]   w_det_in;

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Corner sets are packed as eight 10-bit coordinates; all must be within TOL.
    function automatic logic sets_match(input logic [79:0] a, input logic [79:0] b);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (abs_diff(a[k*10 +: 10], b[k*10 +: 10]) > 10'(TOL)) ok = 1'b0;
        end
        return ok;
    endfunction

    assign w_det_in = {bus.i_det_ul, bus.i_det_ur, bus.i_det_dl, bus.i_det_dr};

    assign w_geom_ok = (bus.i_det_ul[19:10] < 10'd600) && (bus.i_det_ur[19:10] < 10'd600)
                    && (bus.i_det_dl[19:10] < 10'd600) && (bus.i_det_dr[19:10] < 10'd600)
                    && (bus.i_det_ul[9:0] < 10'd800) && (bus.i_det_ur[9:0] < 10'd800)
                    && (bus.i_det_dl[9:0] < 10'd800) && (bus.i_det_dr[9:0] < 10'd800)
                    && (bus.i_det_ul[9:0] < bus.i_det_ur[9:0])
                    && (bus.i_det_dl[9:0] < bus.i_det_dr[9:0])
                    && (bus.i_det_ul[19:10] < bus.i_det_dl[19:10])
                    && (bus.i_det_ur[19:10] < bus.i_det_dr[19:10]);

    assign w_capture    = bus.i_det_valid && w_geom_ok;
    assign w_match_cand = sets_match(r_det, r_cand);
    assign w_match_out  = sets_match(r_det, r_out);

    always_comb begin
        w_acq_cand   = r_cand;
        w_acq_stable = r_stable;
        if (!r_det_valid) begin
            w_acq_stable = '0;
        end else if (w_match_cand) begin
            w_acq_stable = (r_stable >= STABLE_MAX) ? STABLE_MAX : r_stable + 1'b1;
        end else begin
            w_acq_cand   = r_det;
            w_acq_stable = CW'(1);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cand_nxt   = r_cand;
        w_stable_nxt = r_stable;
        w_lost_nxt   = r_lost;
        w_commit     = 1'b0;
        w_commit_en  = 1'b0;
        // User switch-off outranks everything, including a pending solve.
        if (bus.i_frame_start && !bus.i_user_enable && (r_state != S_DISABLED)) begin
            w_state_nxt = S_DISABLED;
            w_commit    = 1'b1;
        end else if (r_state == S_WAIT_XFORM) begin
            if (bus.i_xform_done) begin
                w_state_nxt  = S_LOCKED;
                w_lost_nxt   = '0;
                w_stable_nxt = '0;
            end
        end else if (bus.i_frame_start) begin
            case (r_state)
                S_DISABLED: begin
                    if (bus.i_user_enable) begin
                        w_state_nxt  = S_ACQUIRE;
                        w_stable_nxt = '0;
                        w_lost_nxt   = '0;
                    end
                end
                S_ACQUIRE: begin
                    w_cand_nxt   = w_acq_cand;
                    w_stable_nxt = w_acq_stable;
                    if (w_acq_stable == STABLE_MAX) begin
                        w_commit    = 1'b1;
                        w_commit_en = 1'b1;
                        w_state_nxt = S_WAIT_XFORM;
                    end
                end
                S_LOCKED: begin
                    if (r_det_valid && w_match_out) begin
                        w_lost_nxt   = '0;
                        w_stable_nxt = '0;
                    end else if (r_det_valid) begin
                        w_lost_nxt   = '0;
                        w_cand_nxt   = w_acq_cand;
                        w_stable_nxt = w_acq_stable;
                        if (w_acq_stable == STABLE_MAX) begin
                            w_commit    = 1'b1;
                            w_commit_en = 1'b1;
                            w_state_nxt = S_WAIT_XFORM;
                        end
                    end else begin
                        w_stable_nxt = '0;
                        if ((r_lost + 1'b1) == LOST_MAX) begin
                            w_commit    = 1'b1;
                            w_state_nxt = S_ACQUIRE;
                            w_lost_nxt  = '0;
                        end else begin
                            w_lost_nxt = r_lost + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_DISABLED;
            r_det_valid  <= 1'b0;
            r_det        <= '0;
            r_cand       <= '0;
            r_stable     <= '0;
            r_lost       <= '0;
            r_out        <= '0;
            r_addr_valid <= 1'b0;
            r_enable     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cand       <= w_cand_nxt;
            r_stable     <= w_stable_nxt;
            r_lost       <= w_lost_nxt;
            r_addr_valid <= w_commit;
            if (w_commit) begin
                r_enable <= w_commit_en;
                if (w_commit_en) r_out <= w_cand_nxt;
            end
            // A detection coincident with a frame start belongs to the new frame.
            if (bus.i_frame_start) begin
                r_det_valid <= w_capture;
                if (w_capture) r_det <= w_det_in;
            end else if (w_capture) begin
                r_det_valid <= 1'b1;
                r_det       <= w_det_in;
            end
        end
    end

    assign bus.o_addr_valid = r_addr_valid;
    assign bus.o_enable     = r_enable;
    assign bus.o_ul_addr    = r_out[79:60];
    assign bus.o_ur_addr    = r_out[59:40];
    assign bus.o_dl_addr    = r_out[39:20];
    assign bus.o_dr_addr    = r_out[19:0];
    assign bus.o_locked     = (r_state == S_LOCKED);
    assign bus.o_state      = r_state;
endmodule

// File: tb/tb_corner_lock_scheduler.sv
// Bench for corner_lock_scheduler: directed scenarios followed by random frames,
// every cycle compared against a frame-rule reference model.
module tb_corner_lock_scheduler;
    localparam int STABLE = 4;
    localparam int LOST   = 8;
    localparam int TOL    = 4;
    localparam int M_DIS  = 0;
    localparam int M_ACQ  = 1;
    localparam int M_WAIT = 2;
    localparam int M_LOCK = 3;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    corner_lock_scheduler_if bus();

    corner_lock_scheduler #(
        .STABLE_FRAMES(STABLE),
        .LOST_FRAMES  (LOST),
        .TOL          (TOL)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: corner sets are {ul,ur,dl,dr}, each {row,col}.
    int          m_state;
    bit          m_det_v;
    logic [79:0] m_det;
    logic [79:0] m_cand;
    logic [79:0] m_out;
    bit          m_en;
    bit          m_av;
    int          m_stable;
    int          m_lost;
    logic [80:0] exp_q[$];

    logic [79:0] base_set, shift_set, jit_p, jit_m, bad_set, zero_set;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] mk(input int r, input int c);
        return {10'(r), 10'(c)};
    endfunction

    // Field i: 0 ul.row, 1 ul.col, 2 ur.row, 3 ur.col, 4 dl.row, 5 dl.col, 6 dr.row, 7 dr.col.
    function automatic int fld(input logic [79:0] v, input int i);
        logic [9:0] f;
        f = v[79-10*i -: 10];
        return int'(f);
    endfunction

    function automatic bit geom(input logic [79:0] v);
        for (int i = 0; i < 8; i += 2) begin
            if (fld(v, i) >= 600 || fld(v, i+1) >= 800) return 1'b0;
        end
        return (fld(v, 1) < fld(v, 3)) && (fld(v, 5) < fld(v, 7))
            && (fld(v, 0) < fld(v, 4)) && (fld(v, 2) < fld(v, 6));
    endfunction

    function automatic bit near(input logic [79:0] a, input logic [79:0] b);
        int d;
        for (int i = 0; i < 8; i++) begin
            d = fld(a, i) - fld(b, i);
            if (d < 0) d = -d;
            if (d > TOL) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [79:0] jitter(input logic [79:0] b, input int mag);
        logic [79:0] r;
        int v;
        r = b;
        for (int i = 0; i < 8; i++) begin
            v = fld(b, i) + $urandom_range(0, 2*mag) - mag;
            if (v < 0) v = 0;
            r[79-10*i -: 10] = 10'(v);
        end
        return r;
    endfunction

    function automatic logic [79:0] rand_valid_set();
        int r_top, r_bot, c_l, c_r;
        r_top = $urandom_range(20, 200);
        r_bot = $urandom_range(300, 550);
        c_l   = $urandom_range(20, 300);
        c_r   = $urandom_range(400, 750);
        return {mk(r_top, c_l), mk(r_top + $urandom_range(0, 10), c_r),
                mk(r_bot, c_l + $urandom_range(0, 10)), mk(r_bot, c_r)};
    endfunction

    task automatic track_candidate();
        if (!m_det_v) begin
            m_stable = 0;
        end else if (near(m_det, m_cand)) begin
            m_stable = (m_stable + 1 > STABLE) ? STABLE : m_stable + 1;
        end else begin
            m_cand   = m_det;
            m_stable = 1;
        end
    endtask

    task automatic frame_eval(input bit ue, output bit c, output bit en);
        c  = 1'b0;
        en = 1'b0;
        if (m_state == M_DIS) begin
            if (ue) begin
                m_state  = M_ACQ;
                m_stable = 0;
                m_lost   = 0;
            end
        end else if (m_state == M_ACQ) begin
            track_candidate();
            if (m_stable == STABLE) begin
                c = 1'b1; en = 1'b1; m_state = M_WAIT;
            end
        end else if (m_state == M_LOCK) begin
            if (m_det_v && near(m_det, m_out)) begin
                m_lost = 0; m_stable = 0;
            end else if (m_det_v) begin
                m_lost = 0;
                track_candidate();
                if (m_stable == STABLE) begin
                    c = 1'b1; en = 1'b1; m_state = M_WAIT;
                end
            end else begin
                m_stable = 0;
                m_lost++;
                if (m_lost == LOST) begin
                    c = 1'b1; m_state = M_ACQ; m_lost = 0;
                end
            end
        end
    endtask

    task automatic model_step(input bit r, input bit fs, input bit ue, input bit dv,
                              input logic [79:0] det, input bit xd);
        bit cap, c, en;
        cap  = dv && geom(det);
        c    = 1'b0;
        en   = 1'b0;
        m_av = 1'b0;
        if (r) begin
            m_state = M_DIS; m_det_v = 1'b0; m_det = '0; m_cand = '0; m_out = '0;
            m_en = 1'b0; m_stable = 0; m_lost = 0;
            exp_q.delete();
        end else begin
            if (fs && !ue && m_state != M_DIS) begin
                m_state = M_DIS; c = 1'b1;
            end else if (m_state == M_WAIT) begin
                if (xd) begin
                    m_state = M_LOCK; m_lost = 0; m_stable = 0;
                end
            end else if (fs) begin
                frame_eval(ue, c, en);
            end
            if (c) begin
                m_av = 1'b1;
                m_en = en;
                if (en) m_out = m_cand;
                exp_q.push_back({en, m_out});
            end
            if (fs) begin
                m_det_v = cap;
                if (cap) m_det = det;
            end else if (cap) begin
                m_det_v = 1'b1;
                m_det   = det;
            end
        end
    endtask

    task automatic tick(input bit fs, input bit ue, input bit dv, input logic [79:0] det, input bit xd);
        logic [80:0] e;
        @(negedge clk);
        bus.i_frame_start = fs;
        bus.i_user_enable = ue;
        bus.i_det_valid   = dv;
        bus.i_det_ul      = det[79:60];
        bus.i_det_ur      = det[59:40];
        bus.i_det_dl      = det[39:20];
        bus.i_det_dr      = det[19:0];
        bus.i_xform_done  = xd;
        model_step(rst, fs, ue, dv, det, xd);
        @(posedge clk);
        #1;
        check("addr_valid", 80'(bus.o_addr_valid), 80'(m_av));
        check("state", 80'(bus.o_state), 80'(m_state));
        check("locked", 80'(bus.o_locked), 80'(m_state == M_LOCK));
        check("enable", 80'(bus.o_enable), 80'(m_en));
        check("corners", {bus.o_ul_addr, bus.o_ur_addr, bus.o_dl_addr, bus.o_dr_addr}, m_out);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("commit", {bus.o_enable, bus.o_ul_addr, bus.o_ur_addr, bus.o_dl_addr, bus.o_dr_addr}, e);
        end
    endtask

    // Six-cycle frame: optional detection on the frame-start cycle, one mid-frame
    // detection on cycle 2, solver-done pulse on cycle 0 and/or cycle 4.
    task automatic frame(input bit ue, input bit dv0, input logic [79:0] d0,
                         input bit dv2, input logic [79:0] d2, input bit xd0, input bit xd4);
        tick(1'b1, ue, dv0, d0, xd0);
        tick(1'b0, ue, 1'b0, zero_set, 1'b0);
        tick(1'b0, ue, dv2, d2, 1'b0);
        tick(1'b0, ue, 1'b0, zero_set, 1'b0);
        tick(1'b0, ue, 1'b0, zero_set, xd4);
        tick(1'b0, ue, 1'b0, zero_set, 1'b0);
    endtask

    task automatic frame_det(input logic [79:0] d, input bit xd4);
        frame(1'b1, 1'b0, zero_set, 1'b1, d, 1'b0, xd4);
    endtask

    task automatic frame_none();
        frame(1'b1, 1'b0, zero_set, 1'b0, zero_set, 1'b0, 1'b0);
    endtask

    task automatic check_outputs(input string tag, input int st, input bit en, input logic [79:0] corners);
        check({tag, "_state"}, 80'(bus.o_state), 80'(st));
        check({tag, "_enable"}, 80'(bus.o_enable), 80'(en));
        check({tag, "_corners"}, {bus.o_ul_addr, bus.o_ur_addr, bus.o_dl_addr, bus.o_dr_addr}, corners);
    endtask

    initial begin
        bit          ue, dv0, dv2, xd0, xd4;
        int          sel;
        logic [79:0] cur, d0, d2;

        total = 0;
        bad   = 0;
        zero_set  = '0;
        base_set  = {mk(50, 100), mk(50, 700), mk(500, 100), mk(500, 700)};
        shift_set = {mk(55, 105), mk(55, 705), mk(505, 105), mk(505, 705)};
        jit_p     = {mk(54, 104), mk(54, 704), mk(504, 104), mk(504, 704)};
        jit_m     = {mk(46, 96),  mk(46, 696), mk(496, 96),  mk(496, 696)};
        bad_set   = {mk(50, 700), mk(50, 100), mk(500, 100), mk(500, 700)};
        bus.i_frame_start = 1'b0;
        bus.i_user_enable = 1'b0;
        bus.i_det_valid   = 1'b0;
        bus.i_det_ul      = '0;
        bus.i_det_ur      = '0;
        bus.i_det_dl      = '0;
        bus.i_det_dr      = '0;
        bus.i_xform_done  = 1'b0;

        // Reset with detections present, then idle with the switch off.
        rst = 1'b1;
        tick(1'b1, 1'b0, 1'b1, base_set, 1'b0);
        tick(1'b0, 1'b0, 1'b1, base_set, 1'b0);
        rst = 1'b0;
        check_outputs("reset", M_DIS, 1'b0, zero_set);
        for (int i = 0; i < 10; i++) frame(1'b0, 1'b0, zero_set, 1'b1, base_set, 1'b0, 1'b0);
        check_outputs("idle", M_DIS, 1'b0, zero_set);

        // Lock acquisition: enabling frame, then four evaluated frames.
        for (int i = 0; i < 5; i++) frame_det(base_set, 1'b0);
        check_outputs("acquire", M_WAIT, 1'b1, base_set);
        frame_det(base_set, 1'b1);
        check("lock_locked", 80'(bus.o_locked), 80'(1));

        // Jitter within tolerance, then a sustained 5 px shift.
        for (int i = 0; i < 6; i++) frame_det((i % 2 == 0) ? jit_p : jit_m, 1'b0);
        check_outputs("jitter", M_LOCK, 1'b1, base_set);
        for (int i = 0; i < 5; i++) frame_det(shift_set, 1'b0);
        check_outputs("shift", M_WAIT, 1'b1, shift_set);
        frame_det(shift_set, 1'b1);

        // Loss: a detection on frame 7 restarts the count, then a full loss.
        for (int i = 0; i < 6; i++) frame_none();
        frame_det(shift_set, 1'b0);
        for (int i = 0; i < 7; i++) frame_none();
        check_outputs("loss_reset", M_LOCK, 1'b1, shift_set);
        for (int i = 0; i < 2; i++) frame_none();
        check_outputs("loss", M_ACQ, 1'b0, shift_set);

        // Invalid geometry never captured; coincident detections land a frame later.
        for (int i = 0; i < 6; i++) frame_det(bad_set, 1'b0);
        check_outputs("bad_geom", M_ACQ, 1'b0, shift_set);
        for (int i = 0; i < 4; i++) frame(1'b1, 1'b1, base_set, 1'b0, zero_set, 1'b0, 1'b0);
        check_outputs("coincident", M_ACQ, 1'b0, shift_set);
        frame_none();
        check_outputs("coincident_commit", M_WAIT, 1'b1, base_set);

        // User disable while waiting for the solver; late solve-done ignored.
        frame(1'b0, 1'b0, zero_set, 1'b0, zero_set, 1'b0, 1'b1);
        check_outputs("disable", M_DIS, 1'b0, base_set);
        frame(1'b0, 1'b0, zero_set, 1'b0, zero_set, 1'b1, 1'b1);
        check_outputs("late_xform", M_DIS, 1'b0, base_set);

        // Random frames around a slowly changing target.
        cur = base_set;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 29) == 0) cur = rand_valid_set();
            ue  = ($urandom_range(0, 24) != 0);
            sel = $urandom_range(0, 9);
            dv2 = (sel >= 2);
            d2  = (sel == 2) ? {$urandom(), $urandom(), 16'($urandom())} : jitter(cur, $urandom_range(0, 6));
            dv0 = ($urandom_range(0, 7) == 0);
            d0  = jitter(cur, $urandom_range(0, 3));
            xd0 = ($urandom_range(0, 9) == 0);
            xd4 = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                tick(1'b0, ue, 1'b0, zero_set, 1'b0);
                rst = 1'b0;
            end
            frame(ue, dv0, d0, dv2, d2, xd0, xd4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/corner_lock_scheduler.md
# corner_lock_scheduler

Sequences the perspective-overlay pipeline: filters per-frame corner detections, decides when the overlay turns on or off, and issues the corner-address/enable update pulses (`addr_valid`, `enable`, four `{row,col}` corners) that drive the image generator. Updates are issued only at frame boundaries and only after the previous perspective solve has finished, so the display never tears or sees half-updated coefficients.

## Interface
- `STABLE_FRAMES`, default 4: consecutive matching frames needed to commit a corner set.
- `LOST_FRAMES`, default 8: consecutive frames without a valid detection before the overlay is dropped.
- `TOL`, default 4: per-coordinate match tolerance, in pixels.

- `i_clk`, input, 1: clock.
- `i_rst`, input, 1: reset, synchronous, active-high.
- `i_frame_start`, input, 1: one-cycle pulse at the start of each displayed frame.
- `i_user_enable`, input, 1: level. Overlay requested by the user switch.
- `i_det_valid`, input, 1: one-cycle pulse; detector corner set is valid.
- `i_det_ul`, `i_det_ur`, `i_det_dl`, `i_det_dr`, input, 20 each: `{row[19:10], col[9:0]}`.
- `i_xform_done`, input, 1: one-cycle pulse; downstream perspective solve complete.
- `o_addr_valid`, output, 1: one-cycle update strobe.
- `o_enable`, output, 1: enable value qualified by `o_addr_valid`.
- `o_ul_addr`, `o_ur_addr`, `o_dl_addr`, `o_dr_addr`, output, 20 each: committed corners.
- `o_locked`, output, 1: high while overlay is committed and active.
- `o_state`, output, 2: 0 DISABLED, 1 ACQUIRE, 2 WAIT_XFORM, 3 LOCKED.

## Operation
**Detection capture**
- A detection register holds `{valid, 4 corners}`.
- On `i_det_valid` it loads the set, but only if the set passes the geometry check. Otherwise it is ignored.
- The last valid set within a frame wins.
- Geometry check:
  - all rows < 600 and all cols < 800;
  - ul.col < ur.col, dl.col < dr.col;
  - ul.row < dl.row, ur.row < dr.row.
- At `i_frame_start` the register is evaluated, then cleared.
- If `i_det_valid` and `i_frame_start` arrive in the same cycle, the new set belongs to the new frame. It is captured after the clear.

**Match rule**
- Two corner sets match when |Δrow| ≤ TOL and |Δcol| ≤ TOL for all 8 coordinates.
- Differences are 10-bit unsigned with an absolute value taken; no wrap.

**Frame evaluation** (at each `i_frame_start`), by state:
- **DISABLED**
  - If `i_user_enable`: go to ACQUIRE and clear the counters.
- **ACQUIRE**
  - No detection: stable_cnt = 0.
  - Detection matches the candidate: stable_cnt += 1, saturating at STABLE_FRAMES.
  - Otherwise: candidate = detection, stable_cnt = 1.
  - When stable_cnt reaches STABLE_FRAMES: commit the candidate with enable = 1 and go to WAIT_XFORM.
- **WAIT_XFORM**
  - Ignores frame evaluation.
  - On `i_xform_done`: go to LOCKED with lost_cnt = 0 and stable_cnt = 0.
- **LOCKED**
  - Detection matches the committed set: lost_cnt = 0, stable_cnt = 0.
  - Detection differs: run the ACQUIRE candidate logic. Reaching STABLE_FRAMES recommits (enable = 1) and goes to WAIT_XFORM.
  - No detection: lost_cnt += 1. At LOST_FRAMES, commit with enable = 0 and go to ACQUIRE with counters cleared.

**User switch**
- `i_user_enable` low at any `i_frame_start` outside DISABLED takes priority over all other transitions.
- It commits enable = 0 and goes to DISABLED. In WAIT_XFORM it does not wait for `i_xform_done`.

**Commit**
- Registers the corner outputs when enable = 1. With enable = 0 the corners are held.
- Drives `o_enable` and pulses `o_addr_valid`.
- `o_locked` = (state == LOCKED).

## Timing
- Reset: DISABLED.
  - `o_addr_valid` = 0, `o_enable` = 0, `o_locked` = 0.
  - All corner outputs = 0; counters, candidate and detection register cleared.
- Reset mid-operation returns to these values on the next edge. A pending commit is discarded.
- Commit latency: `o_addr_valid` is high exactly one cycle, the cycle after the `i_frame_start` that triggered it.
  - `o_enable` and the corners are valid in that cycle.
  - The corners are held stable until the next commit.
  - `o_enable` holds its last committed value.
- At most one `o_addr_valid` per frame. None is issued while in WAIT_XFORM, except the user-disable commit.
- `i_xform_done` outside WAIT_XFORM is ignored.
- `i_xform_done` in the same cycle as `i_frame_start`: the transition to LOCKED takes effect and no evaluation runs for that boundary.
- Counter widths: `$clog2(max(STABLE_FRAMES, LOST_FRAMES)+1)`, saturating.

## Test plan
- **Reset/idle:** assert `i_rst` for 2 cycles with `i_user_enable` = 0 and detections present → `o_state` = 0, no `o_addr_valid` for 10 frames.
- **Lock acquisition:** enable; identical valid set ul={50,100}, ur={50,700}, dl={500,100}, dr={500,700} for 4 frames → `o_addr_valid` with `o_enable` = 1 one cycle after the 4th evaluating frame start, corners as given, `o_state` = 2. Pulse `i_xform_done` → `o_locked` = 1.
- **Jitter tolerance:** while locked, alternate ±4 px → no `o_addr_valid`. A ±5 px shift sustained for 4 frames → recommit with the new corners.
- **Loss:** while locked, 8 frames without detection → `o_addr_valid` with `o_enable` = 0, `o_state` = 1, corners unchanged. A detection at frame 7 resets the count instead.
- **Invalid geometry/simultaneity:** ul.col = 700 > ur.col = 100 is never captured. A `i_det_valid` coincident with `i_frame_start` counts toward the next frame, shown by the commit arriving one frame later.
- **User disable during WAIT_XFORM:** drop `i_user_enable` before `i_xform_done` → at the next frame start `o_addr_valid` with `o_enable` = 0, `o_state` = 0. A late `i_xform_done` is ignored.
